// File: rtl/ring_decoder.sv
// Ring-counter observer: checks Count_in follows a left rotation, locks after LOCK_CNT good words.
// Optional build macro RING_DEC_ERRCNT_EN adds a saturating Err_count output.
//
// state    | meaning
// UNLOCKED | no one-hot word seen since last break or reset
// SYNC     | scnt consecutive rotation-consistent words seen, not yet enough to lock
// LOCKED   | rotation confirmed; any non-match breaks lock with an Error pulse
module ring_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    localparam int IW      = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Count_in,
    output logic [IW-1:0]    Index,
    output logic             Valid,
    output logic             Locked,
    output logic             Error,
    output logic [7:0]       Rev_count
`ifdef RING_DEC_ERRCNT_EN
    ,
    output logic [7:0]       Err_count
`endif
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNC     = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [3:0]       scnt, scnt_next;
    logic [WIDTH-1:0] prev;
    logic             in_onehot;
    logic             match;
    logic             err_next;
    logic             rev_inc;
    logic [IW-1:0]    enc;

    assign in_onehot = $onehot(Count_in);
    assign match     = $onehot(prev) && (Count_in == {prev[WIDTH-2:0], prev[WIDTH-1]});

    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (Count_in[i]) enc = IW'(i);
        end
    end

    always_comb begin
        state_next = state;
        scnt_next  = scnt;
        err_next   = 1'b0;
        rev_inc    = 1'b0;
        case (state)
            UNLOCKED: begin
                if (in_onehot) begin
                    state_next = SYNC;
                    scnt_next  = 4'd1;
                end
            end
            SYNC: begin
                if (match) begin
                    scnt_next = scnt + 4'd1;
                    if (scnt + 4'd1 == 4'(LOCK_CNT)) state_next = LOCKED;
                end else if (in_onehot) begin
                    scnt_next = 4'd1;
                end else begin
                    state_next = UNLOCKED;
                    scnt_next  = 4'd0;
                end
            end
            LOCKED: begin
                if (!match) begin
                    state_next = UNLOCKED;
                    scnt_next  = 4'd0;
                    err_next   = 1'b1;
                end else if (Count_in == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                    rev_inc = 1'b1;
                end
            end
            default: begin
                state_next = UNLOCKED;
                scnt_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= UNLOCKED;
            scnt      <= 4'd0;
            prev      <= '0;
            Index     <= '0;
            Valid     <= 1'b0;
            Locked    <= 1'b0;
            Error     <= 1'b0;
            Rev_count <= 8'd0;
        end else begin
            state  <= state_next;
            scnt   <= scnt_next;
            prev   <= Count_in;
            Valid  <= in_onehot;
            Locked <= (state_next == LOCKED);
            Error  <= err_next;
            if (in_onehot) Index <= enc;
            if (rev_inc) Rev_count <= Rev_count + 8'd1;
        end
    end

`ifdef RING_DEC_ERRCNT_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Err_count <= 8'd0;
        end else if (err_next && (Err_count != 8'hFF)) begin
            Err_count <= Err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: directed table, hand sequences and random words against a run-length model.
// Honours RING_DEC_ERRCNT_EN to also cover Err_count.
module tb_ring_decoder;
    localparam int W  = 4;
    localparam int LC = 4;
    localparam int IW = 2;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [W-1:0]  Count_in = '0;
    logic [IW-1:0] Index;
    logic          Valid, Locked, Error;
    logic [7:0]    Rev_count;
`ifdef RING_DEC_ERRCNT_EN
    logic [7:0]    Err_count;
`endif

    ring_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
        .Clock(Clock), .Reset(Reset), .Count_in(Count_in),
        .Index(Index), .Valid(Valid), .Locked(Locked), .Error(Error),
        .Rev_count(Rev_count)
`ifdef RING_DEC_ERRCNT_EN
        , .Err_count(Err_count)
`endif
    );

    always #10 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: length of the current rotation chain plus lock flag.
    logic [W-1:0]  m_prev;
    int            m_run;
    logic          m_locked, m_err, m_valid;
    logic [IW-1:0] m_index;
    logic [7:0]    m_rev, m_errcnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_run = 0; m_locked = 0; m_err = 0; m_valid = 0;
        m_index = '0; m_rev = 0; m_errcnt = 0;
    endtask

    task automatic model_step(input logic [W-1:0] w);
        logic is1, match, brk;
        logic [W-1:0] rot;
        is1   = ($countones(w) == 1);
        rot   = W'((m_prev * 2) % (1 << W)) | W'(m_prev / (1 << (W - 1)));
        match = ($countones(m_prev) == 1) && (w == rot);
        brk   = m_locked && !match;
        if (m_locked && match && w == 1) m_rev = m_rev + 8'd1;
        if (brk) m_run = 0;
        else if (match) m_run = m_run + 1;
        else m_run = is1 ? 1 : 0;
        m_locked = m_locked ? match : (m_run >= LC);
        m_err = brk;
        if (brk && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
        m_valid = is1;
        if (is1) m_index = IW'($clog2(w));
        m_prev = w;
    endtask

    task automatic step(input logic [W-1:0] w);
        @(negedge Clock);
        Count_in = w;
        @(posedge Clock);
        model_step(w);
        #1;
        check("model", {Index, Valid, Locked, Error, Rev_count},
                       {m_index, m_valid, m_locked, m_err, m_rev});
`ifdef RING_DEC_ERRCNT_EN
        check("err_count", Err_count, m_errcnt);
`endif
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Count_in = '0;
        Reset = 1'b1;
        #5;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic revs(input int n);
        for (int r = 0; r < n; r++) begin
            step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
        end
    endtask

    typedef struct {
        logic [W-1:0]  word;
        logic          valid, locked, error;
        logic [IW-1:0] index;
        logic [7:0]    rev;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{4'b0001, 1, 0, 0, 2'd0, 8'd0};
        tbl[1]  = '{4'b0010, 1, 0, 0, 2'd1, 8'd0};
        tbl[2]  = '{4'b0100, 1, 0, 0, 2'd2, 8'd0};
        tbl[3]  = '{4'b1000, 1, 1, 0, 2'd3, 8'd0};
        tbl[4]  = '{4'b0001, 1, 1, 0, 2'd0, 8'd1};
        tbl[5]  = '{4'b0010, 1, 1, 0, 2'd1, 8'd1};
        tbl[6]  = '{4'b0101, 0, 0, 1, 2'd1, 8'd1};
        tbl[7]  = '{4'b0101, 0, 0, 0, 2'd1, 8'd1};
        tbl[8]  = '{4'b0001, 1, 0, 0, 2'd0, 8'd1};
        tbl[9]  = '{4'b0100, 1, 0, 0, 2'd2, 8'd1};
        tbl[10] = '{4'b1000, 1, 0, 0, 2'd3, 8'd1};
        tbl[11] = '{4'b0001, 1, 0, 0, 2'd0, 8'd1};
        tbl[12] = '{4'b0010, 1, 1, 0, 2'd1, 8'd1};

        model_reset();
        #40;
        check("reset_outs", {Index, Valid, Locked, Error, Rev_count}, '0);
        #10 Reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].word);
            check($sformatf("tbl[%0d]", i), {Index, Valid, Locked, Error, Rev_count},
                  {tbl[i].index, tbl[i].valid, tbl[i].locked, tbl[i].error, tbl[i].rev});
        end
`ifdef RING_DEC_ERRCNT_EN
        check("err_count_one", Err_count, 8'd1);
`endif

        do_reset();
        step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
        check("locked_after_4", Locked, 1'b1);
        revs(10);
        check("rev_10", Rev_count, 8'd10);

        @(negedge Clock);
        Count_in = '0;
        #2 Reset = 1'b1;
        #1;
        check("async_reset", {Index, Valid, Locked, Error, Rev_count}, '0);
`ifdef RING_DEC_ERRCNT_EN
        check("async_reset_errcnt", Err_count, 8'd0);
`endif
        #2 Reset = 1'b0;
        model_reset();

        step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
        revs(256);
        check("rev_wrap", Rev_count, 8'd0);

`ifdef RING_DEC_ERRCNT_EN
        for (int e = 0; e < 300; e++) begin
            step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
            step(4'b0101);
        end
        check("err_sat", Err_count, 8'd255);
`endif

        do_reset();
        begin
            logic [W-1:0] w;
            w = 4'b0001;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 9) < 8)
                    w = {w[W-2:0], w[W-1]};
                else
                    w = W'($urandom_range(0, (1 << W) - 1));
                if (w == '0 && $urandom_range(0, 1) == 1) w = 4'b0001;
                step(w);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule
